bus_arbiter_2m: RTL and testbench



---
 rtl/bus_arbiter_2m_pkg.sv | 12 +
 rtl/bus_master_mux.sv | 66 ++++++
 rtl/mx2.sv | 11 +
 rtl/mx2_16bits.sv | 11 +
 rtl/mx2_64bits.sv | 11 +
 rtl/bus_arbiter_2m.sv | 120 ++++++++++++
 tb/tb_bus_arbiter_2m.sv | 180 ++++++++++++++++++
 7 files changed

// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings and default hold limit.
package bus_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/bus_master_mux.sv
// Master-side mux for wr/addr/dout: selects the granted master, drives zeros when no grant.
module bus_master_mux (
  input  logic        sel0,
  input  logic        sel1,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_dout,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_dout,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout
);

  logic        active;
  logic        pick_wr;
  logic [15:0] pick_addr;
  logic [63:0] pick_dout;

  assign active = sel0 | sel1;

  // First stage picks the master, second stage forces zero when nobody owns the bus.
  mx2 u_wr_pick (
    .a0 (m0_wr),
    .a1 (m1_wr),
    .s  (sel1),
    .y  (pick_wr)
  );

  mx2 u_wr_gate (
    .a0 (1'b0),
    .a1 (pick_wr),
    .s  (active),
    .y  (m_wr)
  );

  mx2_16bits u_addr_pick (
    .a0 (m0_addr),
    .a1 (m1_addr),
    .s  (sel1),
    .y  (pick_addr)
  );

  mx2_16bits u_addr_gate (
    .a0 (16'h0000),
    .a1 (pick_addr),
    .s  (active),
    .y  (m_addr)
  );

  mx2_64bits u_dout_pick (
    .a0 (m0_dout),
    .a1 (m1_dout),
    .s  (sel1),
    .y  (pick_dout)
  );

  mx2_64bits u_dout_gate (
    .a0 (64'h0),
    .a1 (pick_dout),
    .s  (active),
    .y  (m_dout)
  );

endmodule

// File: rtl/mx2.sv
// 1-bit 2:1 mux cell.
module mx2 (
  input  logic a0,
  input  logic a1,
  input  logic s,
  output logic y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mx2_16bits.sv
// 16-bit 2:1 mux cell.
module mx2_16bits (
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic        s,
  output logic [15:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mx2_64bits.sv
// 64-bit 2:1 mux cell.
module mx2_64bits (
  input  logic [63:0] a0,
  input  logic [63:0] a1,
  input  logic        s,
  output logic [63:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter with bounded hold time and registered grants.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_lim;
  logic          other_req;

  assign hold_lim = (hold_cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_req) begin
          state_d = GNT0;
        end else if (m1_req) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        // A release takes priority over preemption; both lead to the same place anyway.
        if (!m0_req) begin
          state_d = m1_req ? GNT1 : IDLE;
        end else if (m1_req && hold_lim) begin
          state_d = GNT1;
        end
      end
      GNT1: begin
        if (!m1_req) begin
          state_d = m0_req ? GNT0 : IDLE;
        end else if (m0_req && hold_lim) begin
          state_d = GNT0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    other_req = 1'b0;
    if (state_q == GNT0) begin
      other_req = m1_req;
    end else if (state_q == GNT1) begin
      other_req = m0_req;
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == GNT0) begin
        last_d = 1'b0;
      end else if (state_d == GNT1) begin
        last_d = 1'b1;
      end
    end else if (other_req) begin
      // Only a contested owner counts, so an uncontested count never wraps.
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign m0_grant = (state_q == GNT0);
  assign m1_grant = (state_q == GNT1);
  assign m_req    = m0_grant | m1_grant;

  bus_master_mux u_mux (
    .sel0    (m0_grant),
    .sel1    (m1_grant),
    .m0_wr   (m0_wr),
    .m0_addr (m0_addr),
    .m0_dout (m0_dout),
    .m1_wr   (m1_wr),
    .m1_addr (m1_addr),
    .m1_dout (m1_dout),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_dout  (m_dout)
  );

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed self-checking bench for bus_arbiter_2m with MAX_HOLD=16.
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [63:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant, m_req, m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_arbiter_2m #(
    .MAX_HOLD (16),
    .CW       (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_dout  (m0_dout),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_dout  (m1_dout),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".g0"}, 64'(m0_grant), 64'd0);
    chk({tag, ".g1"}, 64'(m1_grant), 64'd0);
    chk({tag, ".req"}, 64'(m_req), 64'd0);
    chk({tag, ".wr"}, 64'(m_wr), 64'd0);
    chk({tag, ".addr"}, 64'(m_addr), 64'd0);
    chk({tag, ".dout"}, m_dout, 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    m0_req  = 1'b1;
    m0_wr   = 1'b0;
    m0_addr = 16'h0100;
    m0_dout = 64'h0123_4567_89AB_CDEF;
    m1_req  = 1'b1;
    m1_wr   = 1'b1;
    m1_addr = 16'h0200;
    m1_dout = 64'hCAFE_F00D_0000_1111;

    // Reset held 3 cycles with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst");
    end
    reset = 1'b0;

    // First tie after reset goes to M0, then alternate every 16 cycles.
    for (int k = 0; k < 48; k++) begin
      step();
      if (((k / 16) % 2) == 0) begin
        chk("alt.g0", 64'(m0_grant), 64'd1);
        chk("alt.g1", 64'(m1_grant), 64'd0);
        chk("alt.addr", 64'(m_addr), 64'h0100);
      end else begin
        chk("alt.g0", 64'(m0_grant), 64'd0);
        chk("alt.g1", 64'(m1_grant), 64'd1);
        chk("alt.addr", 64'(m_addr), 64'h0200);
        chk("alt.wr", 64'(m_wr), 64'd1);
      end
      chk("alt.req", 64'(m_req), 64'd1);
    end

    // Owner M0 releases with M1 idle -> IDLE with zeroed bus.
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk_idle("rel_idle");

    // M1 alone.
    m1_req  = 1'b1;
    m1_wr   = 1'b1;
    m1_addr = 16'h7010;
    m1_dout = 64'h0000_0000_DEAD_BEEF;
    step();
    chk("m1.g0", 64'(m0_grant), 64'd0);
    chk("m1.g1", 64'(m1_grant), 64'd1);
    chk("m1.req", 64'(m_req), 64'd1);
    chk("m1.wr", 64'(m_wr), 64'd1);
    chk("m1.addr", 64'(m_addr), 64'h7010);
    chk("m1.dout", m_dout, 64'h0000_0000_DEAD_BEEF);
    m1_req = 1'b0;
    step();
    chk_idle("m1_rel");

    // M0 uncontested for 40 cycles: no preemption.
    m0_req  = 1'b1;
    m0_wr   = 1'b1;
    m0_addr = 16'h0100;
    m0_dout = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("long.g0", 64'(m0_grant), 64'd1);
      chk("long.g1", 64'(m1_grant), 64'd0);
    end
    chk("long.dout", m_dout, 64'h1111_2222_3333_4444);
    chk("long.wr", 64'(m_wr), 64'd1);

    // M1 raises request: M0 keeps 16 contested cycles (this one plus 15), then M1.
    m1_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("pre.g0", 64'(m0_grant), 64'd1);
    end
    step();
    chk("pre.g0_off", 64'(m0_grant), 64'd0);
    chk("pre.g1_on", 64'(m1_grant), 64'd1);
    chk("pre.addr", 64'(m_addr), 64'h7010);

    // M1 releases while M0 waits -> direct handover, no idle cycle.
    m1_req = 1'b0;
    step();
    chk("hand01.g0", 64'(m0_grant), 64'd1);
    chk("hand01.g1", 64'(m1_grant), 64'd0);

    // M0 releases as M1 requests in the same cycle -> honoured immediately.
    m0_req = 1'b0;
    m1_req = 1'b1;
    step();
    chk("hand10.g1", 64'(m1_grant), 64'd1);
    chk("hand10.g0", 64'(m0_grant), 64'd0);
    chk("hand10.addr", 64'(m_addr), 64'h7010);

    // Reset during GNT1 drops the grant on the next edge.
    m0_req = 1'b1;
    reset  = 1'b1;
    step();
    chk_idle("rst_g1");
    reset = 1'b0;
    step();
    chk("rst_g1.tie_g0", 64'(m0_grant), 64'd1);
    chk("rst_g1.tie_g1", 64'(m1_grant), 64'd0);

    // Reset during GNT0 must restore last=1, so the next tie still goes to M0.
    reset = 1'b1;
    step();
    chk_idle("rst_g0");
    reset = 1'b0;
    step();
    chk("rst_g0.tie_g0", 64'(m0_grant), 64'd1);
    chk("rst_g0.tie_g1", 64'(m1_grant), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
